gated_prod_accum: RTL and testbench

- Sequential producer of the 17-bit gated sum-of-products word consumed by the downstream word-level arithmetic checker.
- Accepts one product term per beat over a valid/ready stream: multiplicand, multiplier and gate bit.
- Accumulates a*b for every term whose gate is 0, modulo 2^OW. A per-frame offset is added once.
- Presents the frame result on a valid/ready output.

---
 rtl/gated_prod_pkg.sv | 33 +++
 rtl/gated_prod_accum_mul_stage.sv | 43 ++++
 rtl/gated_prod_accum.sv | 179 +++++++++++++++++
 tb/tb_gated_prod_accum.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gated_prod_pkg.sv
// Shared types, default widths and the gated multiply helper for the
// gated sum-of-products accumulator.
package gated_prod_pkg;

    localparam int DEF_AW        = 9;
    localparam int DEF_BW        = 8;
    localparam int DEF_OW        = 17;
    localparam int DEF_OFFW      = 7;
    localparam int DEF_MAX_TERMS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Full-width product, forced to zero for gated terms.
    function automatic logic [DEF_OW-1:0] gated_mul(
        input logic [DEF_AW-1:0] a,
        input logic [DEF_BW-1:0] b,
        input logic              gate
    );
        logic [DEF_AW+DEF_BW-1:0] w_p;
        w_p = {{DEF_BW{1'b0}}, a} * {{DEF_AW{1'b0}}, b};
        if (gate) begin
            gated_mul = {DEF_OW{1'b0}};
        end else begin
            gated_mul = DEF_OW'(w_p);
        end
    endfunction

endpackage

// File: rtl/gated_prod_accum_mul_stage.sv
// Stage-1 registered gated multiplier; valid and last travel with the product.
module gated_mul_stage
    import gated_prod_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [DEF_AW-1:0] i_a,
    input  logic [DEF_BW-1:0] i_b,
    input  logic              i_gate,
    input  logic              i_last,
    output logic              o_valid,
    output logic [DEF_OW-1:0] o_prod,
    output logic              o_last
);

    logic              r_valid;
    logic [DEF_OW-1:0] r_prod;
    logic              r_last;

    // Product register: payload only loads on an accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_prod  <= {DEF_OW{1'b0}};
            r_last  <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_prod <= gated_mul(i_a, i_b, i_gate);
                r_last <= i_last;
            end else begin
                r_prod <= r_prod;
                r_last <= r_last;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_prod  = r_prod;
    assign o_last  = r_last;

endmodule

// File: rtl/gated_prod_accum.sv
// Frame accumulator: sums gated a*b terms plus a per-frame offset (mod 2^OW)
// and presents the result, term count and overflow flag on a valid/ready port.
module gated_prod_accum
    import gated_prod_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int BW        = DEF_BW,
    parameter int OW        = DEF_OW,
    parameter int OFFW      = DEF_OFFW,
    parameter int MAX_TERMS = DEF_MAX_TERMS
)(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [AW-1:0]                    in_a,
    input  logic [BW-1:0]                    in_b,
    input  logic                             in_gate,
    input  logic                             in_last,
    input  logic [OFFW-1:0]                  in_offset,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OW-1:0]                    out_sum,
    output logic [$clog2(MAX_TERMS+1)-1:0]   out_cnt,
    output logic                             out_ovf
);

    localparam int CW = $clog2(MAX_TERMS + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_in_ready;
    logic [OW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            r_fin;
    logic            r_out_valid;
    logic [OW-1:0]   r_out_sum;
    logic [CW-1:0]   r_out_cnt;
    logic            r_out_ovf;

    logic            w_xfer;
    logic            w_first;
    logic            w_emit;
    logic            w_ovf_hit;
    logic            w_p_valid;
    logic [OW-1:0]   w_p_prod;
    logic            w_p_last;

    assign w_xfer    = in_valid & r_in_ready;
    assign w_first   = w_xfer & (r_state == ST_IDLE);
    assign w_emit    = (r_state == ST_DRAIN) & r_fin;
    assign w_ovf_hit = w_xfer & ~in_last & (w_cnt_nxt == CW'(MAX_TERMS));

    gated_mul_stage u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_xfer),
        .i_a     (in_a),
        .i_b     (in_b),
        .i_gate  (in_gate),
        .i_last  (in_last),
        .o_valid (w_p_valid),
        .o_prod  (w_p_prod),
        .o_last  (w_p_last)
    );

    // Next-state and saturating term count
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_first) begin
            w_cnt_nxt = CW'(1);
        end else if (r_cnt == CW'(MAX_TERMS)) begin
            w_cnt_nxt = r_cnt;
        end else begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = in_last ? ST_DRAIN : ST_ACC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (w_xfer && in_last) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_ACC;
                end
            end
            ST_DRAIN: begin
                if (r_fin) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, ready and accumulation registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_acc      <= {OW{1'b0}};
            r_cnt      <= {CW{1'b0}};
            r_fin      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ACC);
            // The offset enters only through the load; the adder never sees it
            if (w_first) begin
                r_acc <= {{(OW-OFFW){1'b0}}, in_offset};
            end else if (w_p_valid) begin
                r_acc <= r_acc + w_p_prod;
            end else begin
                r_acc <= r_acc;
            end
            if (w_xfer) begin
                r_cnt <= w_cnt_nxt;
            end else begin
                r_cnt <= r_cnt;
            end
            if (w_p_valid && w_p_last) begin
                r_fin <= 1'b1;
            end else if (w_emit) begin
                r_fin <= 1'b0;
            end else begin
                r_fin <= r_fin;
            end
        end
    end

    // Result port registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= {OW{1'b0}};
            r_out_cnt   <= {CW{1'b0}};
            r_out_ovf   <= 1'b0;
        end else begin
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_sum   <= r_acc;
                r_out_cnt   <= r_cnt;
            end else if ((r_state == ST_DONE) && out_ready) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
            if (w_first) begin
                r_out_ovf <= w_ovf_hit;
            end else if (w_ovf_hit) begin
                r_out_ovf <= 1'b1;
            end else begin
                r_out_ovf <= r_out_ovf;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_cnt   = r_out_cnt;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_gated_prod_accum.sv
// Scoreboard bench for gated_prod_accum: directed frames from the test plan
// plus randomized frames with idle gaps and random output backpressure.
module tb_gated_prod_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_a;
    logic [7:0]  in_b;
    logic        in_gate;
    logic        in_last;
    logic [6:0]  in_offset;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_sum;
    logic [3:0]  out_cnt;
    logic        out_ovf;

    typedef struct {
        int sum;
        int cnt;
        int ovf;
        int lcyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   hs_cyc = 0;
    int   first_xc = 0;
    bit   hold_rdy = 1'b0;
    bit   rnd_rdy  = 1'b0;
    int   fa[16];
    int   fb[16];
    bit   fg[16];

    gated_prod_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_gate   (in_gate),
        .in_last   (in_last),
        .in_offset (in_offset),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not end (cyc=%0d)", cyc);
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Consumer readiness: forced low, random, or always ready.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (hold_rdy) out_ready = 1'b0;
            else if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
            else out_ready = 1'b1;
        end
    end

    // Monitor: every presented result must match the oldest expected frame.
    initial begin
        bit pv;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    if (!pv) chk("latency", cyc - q[0].lcyc, 2);
                    chk("out_sum", int'(out_sum), q[0].sum);
                    chk("out_cnt", int'(out_cnt), q[0].cnt);
                    chk("out_ovf", int'(out_ovf), q[0].ovf);
                    chk("in_ready_while_done", int'(in_ready), 0);
                    if (out_ready) begin
                        hs_cyc = cyc + 1;
                        void'(q.pop_front());
                    end
                end
            end
            pv = rst_n && out_valid;
        end
    end

    // Hold one beat until accepted; xc is the cycle count after the transfer edge.
    task automatic send_beat(input int a, input int b, input bit g, input bit last,
                             input int off, output int xc);
        bit acc;
        int w;
        in_valid  = 1'b1;
        in_a      = a[8:0];
        in_b      = b[7:0];
        in_gate   = g;
        in_last   = last;
        in_offset = off[6:0];
        acc = 1'b0;
        w   = 0;
        while (!acc && w < 200) begin
            @(negedge clk);
            acc = in_ready;
            w++;
            @(posedge clk);
            #1;
        end
        xc = cyc;
        if (!acc) chk("beat_accept_timeout", 0, 1);
    endtask

    // Reference: offset plus every ungated a*b, wrapped at 2^17.
    task automatic send_frame(input int n, input int off, input bit gaps);
        exp_t e;
        int   s;
        int   xc;
        s = off;
        for (int i = 0; i < n; i++) if (!fg[i]) s = s + fa[i] * fb[i];
        e.sum = s % 131072;
        e.cnt = (n > 8) ? 8 : n;
        e.ovf = (n > 8) ? 1 : 0;
        xc = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            send_beat(fa[i], fb[i], fg[i], i == n - 1,
                      (i == 0) ? off : int'($urandom_range(0, 127)), xc);
            if (i == 0) first_xc = xc;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        e.lcyc = xc;
        q.push_back(e);
    endtask

    task automatic set_term(input int i, input int a, input int b, input bit g);
        fa[i] = a;
        fb[i] = b;
        fg[i] = g;
    endtask

    task automatic wait_drained();
        int w;
        w = 0;
        while (q.size() != 0 && w < 500) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        int xc;
        int n;
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = 9'd0; in_b = 8'd0; in_gate = 1'b0;
        in_last = 1'b0; in_offset = 7'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_out_cnt", int'(out_cnt), 0);
        chk("rst_out_ovf", int'(out_ovf), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain frame: 5 + 12 + 100
        set_term(0, 3, 4, 1'b0); set_term(1, 10, 10, 1'b0);
        send_frame(2, 5, 1'b0);
        wait_drained();
        // Gated large term contributes nothing
        set_term(0, 511, 255, 1'b1); set_term(1, 2, 3, 1'b0);
        send_frame(2, 0, 1'b0);
        wait_drained();
        // Wrap-around modulo 2^17
        set_term(0, 511, 255, 1'b0); set_term(1, 511, 255, 1'b0);
        send_frame(2, 127, 1'b0);
        wait_drained();

        // Backpressure; next frame held at the input until the handshake
        hold_rdy = 1'b1;
        set_term(0, 7, 9, 1'b0); set_term(1, 100, 3, 1'b0); set_term(2, 1, 1, 1'b1);
        send_frame(3, 20, 1'b0);
        set_term(0, 6, 6, 1'b0);
        fork
            send_frame(1, 2, 1'b0);
            begin
                int w;
                w = 0;
                while (!out_valid && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                repeat (5) @(posedge clk);
                #1;
                hold_rdy = 1'b0;
            end
        join
        chk("next_frame_after_handshake", first_xc, hs_cyc + 1);
        wait_drained();

        // Overflow: 9 terms, count saturates at 8, then a clean frame
        for (int i = 0; i < 9; i++) set_term(i, 1, 1, 1'b0);
        send_frame(9, 40, 1'b0);
        set_term(0, 4, 5, 1'b0);
        send_frame(1, 0, 1'b0);
        wait_drained();

        // Asynchronous reset mid-frame
        send_beat(50, 50, 1'b0, 1'b0, 9, xc);
        send_beat(60, 60, 1'b0, 1'b0, 9, xc);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_sum", int'(out_sum), 0);
        chk("midrst_out_cnt", int'(out_cnt), 0);
        chk("midrst_out_ovf", int'(out_ovf), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_term(0, 2, 2, 1'b0);
        send_frame(1, 1, 1'b0);
        wait_drained();

        // Randomized frames with idle gaps and random consumer readiness
        rnd_rdy = 1'b1;
        for (int f = 0; f < 30; f++) begin
            n = $urandom_range(1, 11);
            for (int i = 0; i < n; i++)
                set_term(i, $urandom_range(0, 511), $urandom_range(0, 255),
                         1'($urandom_range(0, 3) == 0));
            send_frame(n, $urandom_range(0, 127), 1'b1);
        end
        wait_drained();
        rnd_rdy = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("no_extra_results", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
